// File: rtl/galaga_pkg.sv
// -----------------------------------------------------------------------------
// galaga_pkg
// Shared constants and types for the enemy motion blocks.
//   SCREEN_W/SCREEN_H : visible screen size in pixels
//   SPRITE_W          : square sprite edge in pixels
//   XLIM/YLIM         : largest top-left coordinate that keeps a sprite on screen
//   EXPLODE_*         : explosion sprite base address, frame count, hold strobes
//   vel_t             : signed per-frame velocity
//   enemy_motion_state_e : enemy lifecycle state
// -----------------------------------------------------------------------------
package galaga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 16;
  localparam int XLIM     = SCREEN_W - SPRITE_W;
  localparam int YLIM     = SCREEN_H - SPRITE_W;

  localparam logic [9:0] EXPLODE_BASE  = 10'h020;
  localparam int         EXPLODE_STEPS = 4;
  localparam int         EXPLODE_HOLD  = 4;

  // Counter widths, never narrower than one bit.
  localparam int STEP_W = (EXPLODE_STEPS > 1) ? $clog2(EXPLODE_STEPS) : 1;
  localparam int HOLD_W = (EXPLODE_HOLD  > 1) ? $clog2(EXPLODE_HOLD)  : 1;

  typedef logic signed [9:0] vel_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAlive   = 2'd1,
    StExplode = 2'd2
  } enemy_motion_state_e;

  // Upper-bound clamp used for spawn coordinates.
  function automatic logic [9:0] clamp_hi(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/enemy_axis_step.sv
// -----------------------------------------------------------------------------
// enemy_axis_step
// Combinational single-axis position update: position + signed velocity,
// clamped to [0, P_LIM]. When built with ENEMY_WRAP_EN and P_WRAP=1 the axis
// wraps modulo P_SPAN instead of clamping.
//   i_pos : current position (unsigned pixels)
//   i_vel : per-frame velocity (two's complement)
//   o_pos : next position
// Build macro: ENEMY_WRAP_EN
// -----------------------------------------------------------------------------
module enemy_axis_step
  import galaga_pkg::*;
#(
  parameter int P_LIM  = 624,
  parameter int P_SPAN = 640,
  parameter bit P_WRAP = 1'b0
) (
  input  logic [9:0] i_pos,
  input  vel_t       i_vel,
  output logic [9:0] o_pos
);

  localparam logic signed [11:0] LIM_S  = 12'(P_LIM);
  localparam logic signed [11:0] SPAN_S = 12'(P_SPAN);

`ifdef ENEMY_WRAP_EN
  localparam bit WRAP_ON = P_WRAP;
`else
  localparam bit WRAP_ON = P_WRAP & 1'b0;
`endif

  // One bit beyond the 11-bit sum so a large positive velocity near the far
  // edge cannot alias into a negative value.
  logic signed [11:0] w_sum;
  assign w_sum = $signed({2'b00, i_pos}) + $signed({{2{i_vel[9]}}, i_vel});

  // Clamp or wrap the raw sum back into the screen range.
  always_comb begin
    o_pos = i_pos;
    if (WRAP_ON) begin
      if (w_sum < 12'sd0) begin
        o_pos = 10'(w_sum + SPAN_S);
      end else if (w_sum >= SPAN_S) begin
        o_pos = 10'(w_sum - SPAN_S);
      end else begin
        o_pos = w_sum[9:0];
      end
    end else begin
      if (w_sum < 12'sd0) begin
        o_pos = 10'd0;
      end else if (w_sum > LIM_S) begin
        o_pos = LIM_S[9:0];
      end else begin
        o_pos = w_sum[9:0];
      end
    end
  end

endmodule

// File: rtl/enemy_motion.sv
// -----------------------------------------------------------------------------
// enemy_motion
// Per-enemy position integrator and lifecycle (idle -> alive -> exploding -> idle).
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   frame_i, pause_i       : frame strobe and motion/explosion freeze
//   spawn_i, spawn_x/y_i   : place enemy (idle only), coordinates clamped on load
//   hit_i                  : collision (alive only), starts explosion
//   xvel_i, yvel_i         : signed per-frame velocity
//   addr_i                 : sprite address from sequencer, passed through while alive
//   x_o, y_o               : registered top-left position
//   addr_o                 : sprite address to renderer (combinational mux)
//   alive_o, exploding_o   : registered lifecycle flags
//   done_o                 : registered one-cycle pulse at explosion completion
// Build macro: ENEMY_WRAP_EN (x axis wraps around the screen instead of clamping)
// -----------------------------------------------------------------------------
module enemy_motion
  import galaga_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       frame_i,
  input  logic       pause_i,
  input  logic       spawn_i,
  input  logic [9:0] spawn_x_i,
  input  logic [9:0] spawn_y_i,
  input  logic       hit_i,
  input  logic [9:0] xvel_i,
  input  logic [9:0] yvel_i,
  input  logic [9:0] addr_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic [9:0] addr_o,
  output logic       alive_o,
  output logic       exploding_o,
  output logic       done_o
);

  enemy_motion_state_e r_state, w_state_nx;
  logic [9:0]          r_x, r_y, w_x_nx, w_y_nx, w_x_step, w_y_step;
  logic [STEP_W-1:0]   r_step, w_step_nx;
  logic [HOLD_W-1:0]   r_hold, w_hold_nx;
  logic                r_alive, r_exploding, r_done, w_done_nx;
  logic                w_tick;
  vel_t                w_xvel, w_yvel;

  assign w_tick = frame_i & ~pause_i;
  assign w_xvel = vel_t'(xvel_i);
  assign w_yvel = vel_t'(yvel_i);

  enemy_axis_step #(
    .P_LIM  (XLIM),
    .P_SPAN (SCREEN_W),
    .P_WRAP (1'b1)
  ) u_x_step (
    .i_pos (r_x),
    .i_vel (w_xvel),
    .o_pos (w_x_step)
  );

  enemy_axis_step #(
    .P_LIM  (YLIM),
    .P_SPAN (SCREEN_H),
    .P_WRAP (1'b0)
  ) u_y_step (
    .i_pos (r_y),
    .i_vel (w_yvel),
    .o_pos (w_y_step)
  );

  // Next-state, position and explosion counter logic.
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_step_nx  = r_step;
    w_hold_nx  = r_hold;
    w_done_nx  = 1'b0;
    case (r_state)
      StIdle: begin
        if (spawn_i) begin
          w_state_nx = StAlive;
          w_x_nx     = clamp_hi(spawn_x_i, 10'(XLIM));
          w_y_nx     = clamp_hi(spawn_y_i, 10'(YLIM));
          w_step_nx  = '0;
          w_hold_nx  = '0;
        end else begin
          w_state_nx = StIdle;
        end
      end
      StAlive: begin
        // A hit wins over a same-cycle strobe, so the position freezes here.
        if (hit_i) begin
          w_state_nx = StExplode;
          w_step_nx  = '0;
          w_hold_nx  = '0;
        end else if (w_tick) begin
          w_x_nx = w_x_step;
          w_y_nx = w_y_step;
        end else begin
          w_state_nx = StAlive;
        end
      end
      StExplode: begin
        if (w_tick) begin
          if (r_hold == HOLD_W'(EXPLODE_HOLD - 1)) begin
            w_hold_nx = '0;
            if (r_step == STEP_W'(EXPLODE_STEPS - 1)) begin
              w_state_nx = StIdle;
              w_step_nx  = '0;
              w_done_nx  = 1'b1;
            end else begin
              w_step_nx = r_step + STEP_W'(1);
            end
          end else begin
            w_hold_nx = r_hold + HOLD_W'(1);
          end
        end else begin
          w_state_nx = StExplode;
        end
      end
      default: begin
        w_state_nx = StIdle;
        w_step_nx  = '0;
        w_hold_nx  = '0;
      end
    endcase
  end

  // State, position, counters and registered status flags.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= StIdle;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_step      <= '0;
      r_hold      <= '0;
      r_alive     <= 1'b0;
      r_exploding <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_x         <= w_x_nx;
      r_y         <= w_y_nx;
      r_step      <= w_step_nx;
      r_hold      <= w_hold_nx;
      r_alive     <= (w_state_nx == StAlive);
      r_exploding <= (w_state_nx == StExplode);
      r_done      <= w_done_nx;
    end
  end

  // Sprite address: sequencer while alive, explosion frames while exploding.
  always_comb begin
    addr_o = 10'd0;
    case (r_state)
      StAlive:   addr_o = addr_i;
      StExplode: addr_o = EXPLODE_BASE + 10'(r_step);
      default:   addr_o = 10'd0;
    endcase
  end

  assign x_o         = r_x;
  assign y_o         = r_y;
  assign alive_o     = r_alive;
  assign exploding_o = r_exploding;
  assign done_o      = r_done;

endmodule
